aes_key_expansion: RTL and testbench

AES-128 key schedule that produces the 11 round keys consumed on the `round_key` inputs of the enciphering round stages. It sits directly upstream of the round pipeline. On `init` it latches a 128-bit cipher key and expands one round key per cycle into an internal 11×128 key memory. SubWord goes through an external shared 32-bit S-box port. Round stages read keys combinationally by round index.

---
 rtl/aes_pkg.sv | 24 ++
 rtl/aes_key_round_step.sv | 26 ++
 rtl/aes_key_expansion.sv | 86 ++++++++
 tb/tb_aes_key_expansion.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES constants, round-constant helpers and the key-schedule FSM state type.
package aes_pkg;

  localparam int AES_ROUNDS = 10;
  localparam int AES_NK     = 4;

  // Rcon for rounds 1..10, round 1 in the most significant byte.
  localparam logic [79:0] AES_RCON_TABLE = 80'h01_02_04_08_10_20_40_80_1b_36;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    DONE   = 2'd2
  } key_state_e;

  function automatic logic [7:0] xtime(input logic [7:0] r);
    return {r[6:0], 1'b0} ^ (r[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] rcon_of(input int rnd);
    return AES_RCON_TABLE[8*(AES_ROUNDS-rnd) +: 8];
  endfunction

endpackage

// File: rtl/aes_key_round_step.sv
// One AES-128 key-schedule step: previous round key plus substituted word gives the next key.
module aes_key_round_step
  import aes_pkg::*;
(
  input  logic [32*AES_NK-1:0] i_prev,
  input  logic [31:0]          i_new_sboxw,
  input  logic [7:0]           i_rcon,
  output logic [32*AES_NK-1:0] o_next
);

  logic [31:0] w_t;
  logic [31:0] w_w0;
  logic [31:0] w_w1;
  logic [31:0] w_w2;
  logic [31:0] w_w3;

  // The S-box already ran on w3, so only RotWord and the Rcon fold remain here.
  assign w_t  = {i_new_sboxw[23:0], i_new_sboxw[31:24]} ^ {i_rcon, 24'h0};
  assign w_w0 = i_prev[127:96] ^ w_t;
  assign w_w1 = i_prev[95:64]  ^ w_w0;
  assign w_w2 = i_prev[63:32]  ^ w_w1;
  assign w_w3 = i_prev[31:0]   ^ w_w2;

  assign o_next = {w_w0, w_w1, w_w2, w_w3};

endmodule

// File: rtl/aes_key_expansion.sv
// AES-128 key schedule: expands one round key per cycle into an 11-entry register file
// that the round stages read combinationally by round index.
module aes_key_expansion
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         reset_n,
  input  logic [127:0] key,
  input  logic         init,
  output logic [31:0]  sboxw,
  input  logic [31:0]  new_sboxw,
  input  logic [3:0]   round,
  output logic [127:0] round_key,
  output logic         ready,
  output logic         key_valid
);

  key_state_e   r_state;
  logic [127:0] r_key_mem [0:AES_ROUNDS];
  logic [127:0] r_prev;
  logic [3:0]   r_rnd_ctr;
  logic [7:0]   r_rcon;
  logic         r_ready;
  logic         r_key_valid;
  logic [127:0] w_next_key;

  aes_key_round_step u_step (
    .i_prev      (r_prev),
    .i_new_sboxw (new_sboxw),
    .i_rcon      (r_rcon),
    .o_next      (w_next_key)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_prev      <= '0;
      r_rnd_ctr   <= '0;
      r_rcon      <= 8'h01;
      r_ready     <= 1'b1;
      r_key_valid <= 1'b0;
      for (int i = 0; i <= AES_ROUNDS; i++) begin
        r_key_mem[i] <= '0;
      end
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (init) begin
            r_key_mem[0] <= key;
            r_prev       <= key;
            r_rnd_ctr    <= 4'd1;
            r_rcon       <= 8'h01;
            r_ready      <= 1'b0;
            r_key_valid  <= 1'b0;
            r_state      <= EXPAND;
          end
        end
        EXPAND: begin
          // Init requests are deliberately dropped here; the schedule always runs to completion.
          r_key_mem[r_rnd_ctr] <= w_next_key;
          r_prev               <= w_next_key;
          r_rcon               <= xtime(r_rcon);
          r_rnd_ctr            <= r_rnd_ctr + 4'd1;
          if (r_rnd_ctr == 4'(AES_ROUNDS)) begin
            r_state     <= DONE;
            r_ready     <= 1'b1;
            r_key_valid <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_comb begin
    round_key = '0;
    if (round <= 4'(AES_ROUNDS)) begin
      round_key = r_key_mem[round];
    end
  end

  assign sboxw     = r_prev[31:0];
  assign ready     = r_ready;
  assign key_valid = r_key_valid;

endmodule

// File: tb/tb_aes_key_expansion.sv
// Self-checking bench for aes_key_expansion: S-box modelled from GF(2^8) arithmetic,
// expected schedule computed word-by-word with the textbook FIPS-197 recurrence.
module tb_aes_key_expansion;

  logic         clk;
  logic         reset_n;
  logic [127:0] key;
  logic         init;
  logic [31:0]  sboxw;
  logic [31:0]  new_sboxw;
  logic [3:0]   round;
  logic [127:0] round_key;
  logic         ready;
  logic         key_valid;

  int checkCount = 0;
  int failCount  = 0;
  logic [127:0] expKeys [0:10];

  aes_key_expansion dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .key       (key),
    .init      (init),
    .sboxw     (sboxw),
    .new_sboxw (new_sboxw),
    .round     (round),
    .round_key (round_key),
    .ready     (ready),
    .key_valid (key_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] sboxByte(input logic [7:0] x);
    logic [7:0] inv = 8'h00;
    logic [7:0] s;
    for (int y = 1; y < 256; y++) begin
      if (x != 8'h00 && gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
    end
    s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
        ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    return s;
  endfunction

  function automatic logic [31:0] subWord(input logic [31:0] w);
    return {sboxByte(w[31:24]), sboxByte(w[23:16]), sboxByte(w[15:8]), sboxByte(w[7:0])};
  endfunction

  assign new_sboxw = subWord(sboxw);

  // Reference schedule: the 44-word recurrence from the standard, not the per-round datapath.
  task automatic computeModel(input logic [127:0] k);
    logic [31:0] w [0:43];
    logic [7:0]  rconList [1:10];
    logic [31:0] temp;
    rconList = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      temp = w[i-1];
      if (i % 4 == 0) begin
        temp = subWord({temp[23:0], temp[31:24]}) ^ {rconList[i/4], 24'h0};
      end
      w[i] = w[i-4] ^ temp;
    end
    for (int r = 0; r <= 10; r++) expKeys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic stepClock();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [127:0] k);
    key  = k;
    init = 1'b1;
    stepClock();
    init = 1'b0;
  endtask

  task automatic checkAllKeys(input string tag);
    for (int r = 0; r <= 10; r++) begin
      round = 4'(r);
      #1;
      checkOutput($sformatf("%s_rk%0d", tag, r), round_key, expKeys[r]);
    end
  endtask

  task automatic checkAllZero(input string tag);
    for (int r = 0; r < 16; r++) begin
      round = 4'(r);
      #1;
      checkOutput($sformatf("%s_rk%0d", tag, r), round_key, 128'h0);
    end
  endtask

  initial begin
    int cycles;
    logic [127:0] rk;
    reset_n = 1'b0;
    init    = 1'b0;
    key     = '0;
    round   = '0;
    stepClock();
    stepClock();
    reset_n = 1'b1;

    checkOutput("reset_ready", 128'(ready), 128'd1);
    checkOutput("reset_valid", 128'(key_valid), 128'd0);
    checkOutput("reset_sboxw", 128'(sboxw), 128'd0);
    checkAllZero("reset");

    // FIPS A.1 with progressive readout and an ignored init at edge k+3.
    computeModel(128'h2b7e151628aed2a6abf7158809cf4f3c);
    applyStimulus(128'h2b7e151628aed2a6abf7158809cf4f3c);
    round = 4'd0;
    #1;
    checkOutput("a1_rk0", round_key, expKeys[0]);
    checkOutput("a1_busy", 128'(ready), 128'd0);
    for (int r = 1; r <= 10; r++) begin
      round = 4'(r);
      if (r == 3) begin
        key  = 128'hdeadbeef_01234567_89abcdef_cafef00d;
        init = 1'b1;
      end
      #1;
      checkOutput($sformatf("a1_pre%0d", r), round_key, 128'h0);
      stepClock();
      init = 1'b0;
      checkOutput($sformatf("a1_post%0d", r), round_key, expKeys[r]);
      checkOutput($sformatf("a1_valid%0d", r), 128'(key_valid), (r == 10) ? 128'd1 : 128'd0);
    end
    checkOutput("a1_ready", 128'(ready), 128'd1);
    checkAllKeys("a1");
    round = 4'd1;
    #1;
    checkOutput("a1_fips_r1", round_key, 128'ha0fafe1788542cb123a339392a6c7605);
    round = 4'd10;
    #1;
    checkOutput("a1_fips_r10", round_key, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    for (int r = 11; r < 16; r++) begin
      round = 4'(r);
      #1;
      checkOutput($sformatf("oor_rk%0d", r), round_key, 128'h0);
    end

    // Restart from DONE with the all-zero key.
    computeModel(128'h0);
    applyStimulus(128'h0);
    checkOutput("zero_valid_drop", 128'(key_valid), 128'd0);
    round = 4'd0;
    #1;
    checkOutput("zero_rk0", round_key, 128'h0);
    cycles = 1;
    while (!key_valid && cycles < 25) begin
      stepClock();
      cycles++;
    end
    checkOutput("zero_latency", 128'(cycles), 128'd11);
    checkAllKeys("zero");
    round = 4'd1;
    #1;
    checkOutput("zero_fips_r1", round_key, 128'h62636363626363636263636362636363);
    round = 4'd10;
    #1;
    checkOutput("zero_fips_r10", round_key, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

    // Random keys issued back-to-back as soon as ready returns.
    for (int n = 0; n < 6; n++) begin
      rk = {$urandom, $urandom, $urandom, $urandom};
      computeModel(rk);
      applyStimulus(rk);
      cycles = 1;
      while (!ready && cycles < 25) begin
        stepClock();
        cycles++;
      end
      checkOutput($sformatf("rnd%0d_latency", n), 128'(cycles), 128'd11);
      checkOutput($sformatf("rnd%0d_valid", n), 128'(key_valid), 128'd1);
      checkAllKeys($sformatf("rnd%0d", n));
    end

    // Reset at edge k+5 wins over a simultaneous init.
    rk = {$urandom, $urandom, $urandom, $urandom};
    applyStimulus(rk);
    for (int i = 0; i < 4; i++) stepClock();
    reset_n = 1'b0;
    init    = 1'b1;
    key     = rk;
    stepClock();
    init    = 1'b0;
    reset_n = 1'b1;
    checkOutput("rst_ready", 128'(ready), 128'd1);
    checkOutput("rst_valid", 128'(key_valid), 128'd0);
    checkOutput("rst_sboxw", 128'(sboxw), 128'd0);
    checkAllZero("rst");
    stepClock();
    checkOutput("rst_idle_ready", 128'(ready), 128'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: timeout reached, expected finish");
    $fatal(1, "[TB] timeout");
  end

endmodule
